mig_tt_eval: RTL and testbench
==============================

MIG_TT_EVAL -- requirements
Module: mig_tt_eval

Interface
REQ-001 SHALL have parameter MAX_NODES, default 8, maximum majority nodes per program.
REQ-002 SHALL have parameter NVARS, default 7, primary inputs x0..x6; truth-table width 2^NVARS = 128.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 prog_valid  input  1  node-write request.
REQ-006 prog_ready  output  1  node-write accepted when prog_valid & prog_ready.
REQ-007 prog_idx  input  3  node slot written (w0..w7).
REQ-008 prog_node  input  15  three operands {inv,sel[3:0]}; sel 0=const0, 1..7=x0..x6, 8..15=w0..w7.
REQ-009 num_nodes  input  4  nodes to evaluate (1..8); sampled on start.
REQ-010 out_sel  input  4  output operand select, same encoding; sampled on start.
REQ-011 out_inv  input  1  invert output; sampled on start.
REQ-012 start  input  1  begin evaluation; honoured only in IDLE.
REQ-013 busy  output  1  high in EVAL and OUT.
REQ-014 tt_valid  output  1  truth table available.
REQ-015 tt_ready  input  1  consumer accepts when tt_valid & tt_ready.
REQ-016 tt_data  output  128  bit m = f(x0=m[0], ..., x6=m[6]).
REQ-017 err  output  1  sticky program error; cleared on next accepted start.

Function
REQ-018 Node k SHALL compute MAJ(a,b,c) = ab|ac|bc bit-parallel over all 128 minterms; each operand XORed with its inv bit.
REQ-019 Variable patterns SHALL be constants: x_i bit m = m[i] (x0 = 0xAAAA..., x6 = upper 64 bits set).
REQ-020 States SHALL be IDLE, EVAL, OUT, DONE.
REQ-021 IDLE: prog_ready=1; start -> EVAL with k=0, err cleared.
REQ-022 EVAL: one node per cycle into a 128-bit w_k register; after k=num_nodes-1 -> OUT.
REQ-023 OUT: tt_data <= selected operand ^ {128{out_inv}} -> DONE; tt_valid rises num_nodes+1 cycles after start.
REQ-024 DONE: tt_valid=1, tt_data stable until tt_ready; on handshake -> IDLE.
REQ-025 prog_ready SHALL be 0 outside IDLE; prog_valid outside IDLE is ignored.
REQ-026 prog_valid and start in the same IDLE cycle: write completes first, start uses the new node.
REQ-027 Node k operand selecting w_j with j>=k, num_nodes 0 or >MAX_NODES, or out_sel selecting w_j with j>=num_nodes SHALL set err, abort to IDLE, no tt_valid.
REQ-028 Node program storage SHALL persist across evaluations; it is not cleared by start.

Reset
REQ-029 rst SHALL force IDLE; busy=0, tt_valid=0, err=0, tt_data=0, prog_ready=1 from the next cycle.
REQ-030 rst mid-EVAL/DONE SHALL discard the result; node storage SHALL be cleared to all-zero (const0 operands).

Configuration
REQ-031 MIG_TT_POPCOUNT_EN defined: output tt_ones[7:0] = number of ones in tt_data, registered with tt_data, 0 at reset.
REQ-032 MIG_TT_POPCOUNT_EN undefined: tt_ones port absent; no other behaviour change.

Structure
REQ-033 Package mig_tt_pkg SHALL hold the operand-select encoding constants, operand and node typedefs, the state enum, and the x0..x6 pattern constants.
REQ-034 Sub-module mig_maj3_vec (128-bit three-input majority with per-operand invert) is natural; one instance, reused each cycle.

Verification
REQ-035 Node0 = MAJ(x0,x1,x2), num_nodes=1, out_sel=w0 -> tt_data = 0xE8 repeated 16 times, tt_valid 2 cycles after start; tt_ones=64.
REQ-036 Node0 = MAJ(x0,const0,x1) -> 0x88 repeated; same with inv on const0 -> 0xEE repeated.
REQ-037 Node0 operand sel=w1 with num_nodes=2 -> err=1, tt_valid never asserts, back to IDLE.
REQ-038 tt_ready low 5 cycles in DONE -> tt_data stable, prog_ready=0, start ignored.
REQ-039 rst asserted at EVAL k=1 of a 3-node program -> IDLE next cycle, busy=0, tt_valid=0, subsequent start evaluates cleared nodes -> tt_data=0.

Source files
------------

// File: rtl/mig_tt_pkg.sv
// Shared types and constants for the majority-inverter-graph truth-table evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: operand-select encoding, operand/node typedefs, FSM state enum,
// and the constant truth-table patterns of primary inputs x0..x6.
package mig_tt_pkg;

  localparam int TT_W   = 128;  // 2^7 minterms
  localparam int NODE_W = 15;   // three 5-bit operands

  // Operand select encoding: 0 = const0, 1..7 = x0..x6, 8..15 = w0..w7
  localparam logic [3:0] SEL_CONST0 = 4'd0;
  localparam logic [3:0] SEL_X0     = 4'd1;
  localparam logic [3:0] SEL_W0     = 4'd8;

  typedef struct packed {
    logic       inv;
    logic [3:0] sel;
  } operand_t;

  // Operand a occupies the low 5 bits of prog_node.
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } node_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit m of x_i equals bit i of m.
  localparam logic [TT_W-1:0] X0_PAT = {64{2'b10}};
  localparam logic [TT_W-1:0] X1_PAT = {32{4'b1100}};
  localparam logic [TT_W-1:0] X2_PAT = {16{8'hF0}};
  localparam logic [TT_W-1:0] X3_PAT = {8{16'hFF00}};
  localparam logic [TT_W-1:0] X4_PAT = {4{32'hFFFF_0000}};
  localparam logic [TT_W-1:0] X5_PAT = {2{64'hFFFF_FFFF_0000_0000}};
  localparam logic [TT_W-1:0] X6_PAT = {{64{1'b1}}, {64{1'b0}}};

  localparam logic [6:0][TT_W-1:0] X_PAT =
    {X6_PAT, X5_PAT, X4_PAT, X3_PAT, X2_PAT, X1_PAT, X0_PAT};

endpackage

// File: rtl/mig_maj3_vec.sv
// Bit-parallel three-input majority over a full truth table, each operand optionally inverted.
// Latency: combinational.
// Backpressure: none.
// Ports: a/b/c operand truth tables, a_inv/b_inv/c_inv per-operand inversion, y result.
module mig_maj3_vec
  import mig_tt_pkg::*;
(
  input  logic [TT_W-1:0] a,
  input  logic [TT_W-1:0] b,
  input  logic [TT_W-1:0] c,
  input  logic            a_inv,
  input  logic            b_inv,
  input  logic            c_inv,
  output logic [TT_W-1:0] y
);

  logic [TT_W-1:0] aa;
  logic [TT_W-1:0] bb;
  logic [TT_W-1:0] cc;

  assign aa = a ^ {TT_W{a_inv}};
  assign bb = b ^ {TT_W{b_inv}};
  assign cc = c ^ {TT_W{c_inv}};
  assign y  = (aa & bb) | (aa & cc) | (bb & cc);

endmodule

// File: rtl/mig_tt_eval.sv
// Evaluates a stored majority-node program into a 128-bit truth table, one node per cycle.
// Latency: tt_valid rises num_nodes+1 cycles after an accepted start.
// Backpressure: result held in DONE until tt_ready; program writes and start stalled outside IDLE.
// Ports: clk/rst (sync, active-high); prog_valid/prog_ready/prog_idx/prog_node node writes;
// num_nodes/out_sel/out_inv/start launch evaluation; busy status; tt_valid/tt_ready/tt_data
// result handshake; err sticky program error.
// Option: define MIG_TT_POPCOUNT_EN to add tt_ones, the ones-count of tt_data.
module mig_tt_eval
  import mig_tt_pkg::*;
#(
  parameter int MAX_NODES = 8,
  parameter int NVARS     = 7
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [2:0]        prog_idx,
  input  logic [NODE_W-1:0] prog_node,
  input  logic [3:0]        num_nodes,
  input  logic [3:0]        out_sel,
  input  logic              out_inv,
  input  logic              start,
  output logic              busy,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [TT_W-1:0]   tt_data,
`ifdef MIG_TT_POPCOUNT_EN
  output logic [7:0]        tt_ones,
`endif
  output logic              err
);

  state_t                          state_q, state_d;
  logic [3:0]                      k_q;
  logic [3:0]                      num_q;
  logic [3:0]                      osel_q;
  logic                            oinv_q;
  logic                            err_q;
  node_t [MAX_NODES-1:0]           node_mem;
  logic  [MAX_NODES-1:0][TT_W-1:0] w_q;

  logic            load_cfg, clr_err, set_err, wr_w, load_tt;
  logic            cfg_bad, node_bad;
  node_t           cur;
  logic [TT_W-1:0] op_a, op_b, op_c, maj_y, out_val;

  // Operand value before inversion.
  function automatic logic [TT_W-1:0] operand_val(input logic [3:0] sel,
                                                  input logic [MAX_NODES-1:0][TT_W-1:0] w);
    logic [TT_W-1:0] v;
    v = '0;
    if (sel >= SEL_W0)
      v = w[sel[2:0]];
    else if (sel != SEL_CONST0 && int'(sel) <= NVARS)
      v = X_PAT[3'(sel - SEL_X0)];
    return v;
  endfunction

  // A node may only read results of strictly earlier nodes.
  function automatic logic fwd_ref(input logic [3:0] sel, input logic [3:0] k);
    return sel[3] && ({1'b0, sel[2:0]} >= k);
  endfunction

  assign cur = node_mem[k_q[2:0]];

  always_comb begin
    op_a = operand_val(cur.a.sel, w_q);
    op_b = operand_val(cur.b.sel, w_q);
    op_c = operand_val(cur.c.sel, w_q);
  end

  mig_maj3_vec u_maj (
    .a     (op_a),
    .b     (op_b),
    .c     (op_c),
    .a_inv (cur.a.inv),
    .b_inv (cur.b.inv),
    .c_inv (cur.c.inv),
    .y     (maj_y)
  );

  assign out_val = operand_val(osel_q, w_q) ^ {TT_W{oinv_q}};

  // Launch-time checks use the live inputs, since they are only captured on start.
  assign cfg_bad  = (num_nodes == 4'd0) || (num_nodes > 4'(MAX_NODES)) ||
                    (out_sel[3] && ({1'b0, out_sel[2:0]} >= num_nodes));
  assign node_bad = fwd_ref(cur.a.sel, k_q) || fwd_ref(cur.b.sel, k_q) ||
                    fwd_ref(cur.c.sel, k_q);

  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    clr_err  = 1'b0;
    set_err  = 1'b0;
    wr_w     = 1'b0;
    load_tt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          clr_err  = 1'b1;
          if (cfg_bad) set_err = 1'b1;
          else         state_d = EVAL;
        end
      end
      EVAL: begin
        if (node_bad) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          wr_w = 1'b1;
          if (k_q == num_q - 4'd1) state_d = OUT;
        end
      end
      OUT: begin
        load_tt = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (tt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prog_ready = (state_q == IDLE);
  assign busy       = (state_q == EVAL) || (state_q == OUT);
  assign tt_valid   = (state_q == DONE);
  assign err        = err_q;

`ifdef MIG_TT_POPCOUNT_EN
  logic [7:0] ones_d;
  always_comb begin
    ones_d = '0;
    for (int i = 0; i < TT_W; i++) ones_d = ones_d + 8'(out_val[i]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      num_q    <= '0;
      osel_q   <= '0;
      oinv_q   <= 1'b0;
      err_q    <= 1'b0;
      tt_data  <= '0;
      node_mem <= '0;
      w_q      <= '0;
`ifdef MIG_TT_POPCOUNT_EN
      tt_ones  <= '0;
`endif
    end else begin
      state_q <= state_d;
      // Write lands before a same-cycle start reaches EVAL, so start sees the new node.
      if (prog_valid && prog_ready) node_mem[prog_idx] <= node_t'(prog_node);
      if (load_cfg) begin
        num_q  <= num_nodes;
        osel_q <= out_sel;
        oinv_q <= out_inv;
        k_q    <= '0;
      end
      if (wr_w) begin
        w_q[k_q[2:0]] <= maj_y;
        k_q           <= k_q + 4'd1;
      end
      if (load_tt) begin
        tt_data <= out_val;
`ifdef MIG_TT_POPCOUNT_EN
        tt_ones <= ones_d;
`endif
      end
      if (set_err)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mig_tt_eval.sv
// Scoreboard bench for mig_tt_eval: directed cases plus randomized programs against a
// per-minterm reference model.
module tb_mig_tt_eval;

  logic         clk;
  logic         rst;
  logic         prog_valid;
  logic         prog_ready;
  logic [2:0]   prog_idx;
  logic [14:0]  prog_node;
  logic [3:0]   num_nodes;
  logic [3:0]   out_sel;
  logic         out_inv;
  logic         start;
  logic         busy;
  logic         tt_valid;
  logic         tt_ready;
  logic [127:0] tt_data;
  logic         err;
`ifdef MIG_TT_POPCOUNT_EN
  logic [7:0]   tt_ones;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0]  model_nodes [8];
  logic [127:0] exp_q [$];
  bit           hold_low = 0;
  bit           stall_prev = 0;
  logic [127:0] hold_data;

  mig_tt_eval dut (
    .clk        (clk),
    .rst        (rst),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_idx   (prog_idx),
    .prog_node  (prog_node),
    .num_nodes  (num_nodes),
    .out_sel    (out_sel),
    .out_inv    (out_inv),
    .start      (start),
    .busy       (busy),
    .tt_valid   (tt_valid),
    .tt_ready   (tt_ready),
    .tt_data    (tt_data),
`ifdef MIG_TT_POPCOUNT_EN
    .tt_ones    (tt_ones),
`endif
    .err        (err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand value at minterm m: const0, primary input bit, or earlier node result.
  function automatic logic opbit(input logic [4:0] o, input int m, input logic [7:0] w);
    int   s;
    logic v;
    s = int'(o[3:0]);
    if (s == 0)     v = 1'b0;
    else if (s < 8) v = 1'((m >> (s - 1)) & 1);
    else            v = w[s - 8];
    return v ^ o[4];
  endfunction

  function automatic logic [127:0] model_tt(input int n, input logic [3:0] osel,
                                            input logic oinv, output bit bad);
    logic [127:0] r;
    logic [7:0]   w;
    int           cnt;
    r   = '0;
    bad = 0;
    if (n < 1 || n > 8) bad = 1;
    if (osel >= 8 && int'(osel) - 8 >= n) bad = 1;
    if (!bad)
      for (int k = 0; k < n; k++)
        for (int op = 0; op < 3; op++)
          if (model_nodes[k][5*op+3] && int'(model_nodes[k][5*op +: 4]) - 8 >= k) bad = 1;
    if (bad) return '0;
    for (int m = 0; m < 128; m++) begin
      w = '0;
      for (int k = 0; k < n; k++) begin
        cnt = 0;
        for (int op = 0; op < 3; op++) cnt += int'(opbit(model_nodes[k][5*op +: 5], m, w));
        w[k] = (cnt >= 2);
      end
      r[m] = opbit({oinv, osel}, m, w);
    end
    return r;
  endfunction

  function automatic logic [14:0] mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [4:0] rand_op(input int k);
    logic [3:0] s;
    if ($urandom_range(0, 19) == 0) s = 4'($urandom_range(0, 15));
    else                            s = 4'($urandom_range(0, 7 + k));
    return {1'($urandom_range(0, 1)), s};
  endfunction

  // Consumer: random ready, forced low while hold_low is set.
  initial begin
    tt_ready = 0;
    forever begin
      @(posedge clk); #1;
      tt_ready = hold_low ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expectations on each result handshake; checks stability while stalled.
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst) begin
      if (tt_valid && stall_prev) check("hold_stable", tt_data, hold_data);
      if (tt_valid && tt_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %h expected none", tt_data);
        end else begin
          e = exp_q.pop_front();
          check("tt_data", tt_data, e);
`ifdef MIG_TT_POPCOUNT_EN
          check("tt_ones", 128'(tt_ones), 128'($countones(e)));
`endif
        end
      end
      stall_prev = tt_valid && !tt_ready;
      hold_data  = tt_data;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic prog_write(input logic [2:0] idx, input logic [14:0] nd);
    @(posedge clk); #1;
    prog_valid = 1; prog_idx = idx; prog_node = nd;
    @(posedge clk); #1;
    prog_valid = 0;
    model_nodes[idx] = nd;
  endtask

  task automatic run_eval(input int n, input logic [3:0] osel, input logic oinv,
                          input bit wr, input logic [2:0] widx, input logic [14:0] wnode,
                          input bit stall, input bit lit_en, input logic [127:0] lit);
    bit           bad;
    logic [127:0] e;
    logic [127:0] held;
    int           cyc;
    if (wr) model_nodes[widx] = wnode;
    e = model_tt(n, osel, oinv, bad);
    if (lit_en) e = lit;
    if (!bad) exp_q.push_back(e);
    if (stall) hold_low = 1;
    @(posedge clk); #1;
    num_nodes = 4'(n); out_sel = osel; out_inv = oinv; start = 1;
    if (wr) begin prog_valid = 1; prog_idx = widx; prog_node = wnode; end
    @(posedge clk); #1;
    start = 0; prog_valid = 0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (tt_valid || !busy) break;
      cyc++;
    end
    if (cyc >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL eval_timeout: got no completion expected completion within 40 cycles");
    end else if (bad) begin
      check("err_set", 128'(err), 128'(1));
      check("no_valid", 128'(tt_valid), 128'(0));
    end else begin
      check("latency", 128'(cyc), 128'(n + 1));
      check("err_clr", 128'(err), 128'(0));
      if (stall) begin
        held = tt_data;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          start = 1; num_nodes = 4'd1; out_sel = 4'd1; out_inv = 0;
          prog_valid = 1; prog_idx = 3'd0; prog_node = 15'h7fff;
          @(negedge clk);
          check("stall_valid", 128'(tt_valid), 128'(1));
          check("stall_data", tt_data, held);
          check("stall_prog_ready", 128'(prog_ready), 128'(0));
        end
        @(posedge clk); #1;
        start = 0; prog_valid = 0; hold_low = 0;
      end
    end
    hold_low = 0;
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (prog_ready && exp_q.size() == 0) break;
      cyc++;
    end
    if (cyc >= 60) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    int          n;
    logic [3:0]  osel;
    logic [14:0] nd;
    bit          same;

    rst = 1; prog_valid = 0; prog_idx = 0; prog_node = 0;
    num_nodes = 0; out_sel = 0; out_inv = 0; start = 0;
    for (int i = 0; i < 8; i++) model_nodes[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(tt_valid), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_data", tt_data, 128'(0));
    check("rst_prog_ready", 128'(prog_ready), 128'(1));
    @(posedge clk); #1;
    rst = 0;

    // MAJ(x0,x1,x2) -> 0xE8 pattern
    prog_write(0, mk(5'd1, 5'd2, 5'd3));
    run_eval(1, 4'd8, 0, 0, 0, 0, 0, 1, {16{8'hE8}});
    // Same-cycle write and start: MAJ(x0,const0,x1), then const0 inverted
    run_eval(1, 4'd8, 0, 1, 3'd0, mk(5'd1, 5'd0, 5'd2), 0, 1, {16{8'h88}});
    run_eval(1, 4'd8, 0, 1, 3'd0, mk(5'd1, 5'h10, 5'd2), 0, 1, {16{8'hEE}});
    run_eval(1, 4'd8, 1, 0, 0, 0, 0, 1, {16{8'h11}});
    // Output selecting a primary input directly
    run_eval(1, 4'd7, 0, 0, 0, 0, 0, 1, {{64{1'b1}}, {64{1'b0}}});

    // Program errors
    prog_write(0, mk(5'd9, 5'd1, 5'd2));
    prog_write(1, mk(5'd8, 5'd3, 5'd4));
    run_eval(2, 4'd9, 0, 0, 0, 0, 0, 0, 0);
    prog_write(0, mk(5'd1, 5'd2, 5'd3));
    run_eval(0, 4'd8, 0, 0, 0, 0, 0, 0, 0);
    run_eval(9, 4'd8, 0, 0, 0, 0, 0, 0, 0);
    run_eval(2, 4'd11, 0, 0, 0, 0, 0, 0, 0);
    run_eval(2, 4'd9, 0, 0, 0, 0, 0, 0, 0);

    // Stalled consumer, then persistence of node 0 despite ignored writes
    run_eval(1, 4'd8, 0, 1, 3'd0, mk(5'd1, 5'd2, 5'd3), 1, 1, {16{8'hE8}});
    run_eval(1, 4'd8, 0, 0, 0, 0, 0, 1, {16{8'hE8}});

    // Reset during EVAL k=1 of a 3-node program
    prog_write(1, mk(5'd8, 5'd4, 5'd5));
    prog_write(2, mk(5'd9, 5'd8, 5'd6));
    @(posedge clk); #1;
    num_nodes = 4'd3; out_sel = 4'd10; out_inv = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_valid", 128'(tt_valid), 128'(0));
    check("mid_rst_prog_ready", 128'(prog_ready), 128'(1));
    check("mid_rst_data", tt_data, 128'(0));
    for (int i = 0; i < 8; i++) model_nodes[i] = '0;
    run_eval(1, 4'd8, 0, 0, 0, 0, 0, 1, 128'(0));
    run_eval(3, 4'd10, 0, 0, 0, 0, 0, 1, 128'(0));

    // Randomized programs
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 14) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15));
      else                            n = int'($urandom_range(1, 8));
      for (int k = 0; k < n - 1 && k < 8; k++)
        if ($urandom_range(0, 3) != 0) prog_write(3'(k), mk(rand_op(k), rand_op(k), rand_op(k)));
      if ($urandom_range(0, 19) == 0) osel = 4'($urandom_range(0, 15));
      else                            osel = 4'($urandom_range(0, 7 + ((n > 8) ? 8 : n)));
      same = ($urandom_range(0, 1) == 1);
      if (n >= 1 && n <= 8) begin
        nd = mk(rand_op(n - 1), rand_op(n - 1), rand_op(n - 1));
        if (!same) prog_write(3'(n - 1), nd);
        run_eval(n, osel, 1'($urandom_range(0, 1)), same, 3'(n - 1), nd, 0, 0, 0);
      end else begin
        run_eval(n, osel, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0);
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
